// File: rtl/jtdd_romcache_pkg.sv
// Shared types for the two-entry 6809 ROM read cache.
// FSM encoding and the byte-lane select used by each way.
package jtdd_romcache_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } state_e;

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
    logic [31:0] shifted;
    shifted = word >> {sel, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/jtdd_romcache_if.sv
// CPU-side ROM port plus SDRAM req/ack/dok handshake for jtdd_romcache.
// The cache itself binds to the slave modport.
interface jtdd_romcache_if #(
  parameter int unsigned AW = 18
);
  logic          cpu_cs;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          cpu_ok;
  logic          flush;
  logic          sdram_req;
  logic [AW-3:0] sdram_addr;
  logic          sdram_ack;
  logic          sdram_dok;
  logic [31:0]   sdram_data;

  modport master (
    output cpu_cs, cpu_addr, flush, sdram_ack, sdram_dok, sdram_data,
    input  cpu_data, cpu_ok, sdram_req, sdram_addr
  );

  modport slave (
    input  cpu_cs, cpu_addr, flush, sdram_ack, sdram_dok, sdram_data,
    output cpu_data, cpu_ok, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtdd_romcache_way.sv
// One cache entry: valid/tag/line storage, tag compare and byte select.
// Flush wins over a simultaneous write of the valid bit.
module jtdd_romcache_way
  import jtdd_romcache_pkg::*;
#(
  parameter int unsigned AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [AW-3:0] wr_tag,
  input  logic [31:0]   wr_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [7:0]    dout
);

  logic          valid_q;
  logic [AW-3:0] tag_q;
  logic [31:0]   line_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (wr) begin
        valid_q <= 1'b1;
      end
      if (wr) begin
        tag_q  <= wr_tag;
        line_q <= wr_data;
      end
    end
  end

  assign hit  = cs & valid_q & (tag_q == addr[AW-1:2]);
  assign dout = byte_sel(line_q, addr[1:0]);

endmodule

// File: rtl/jtdd_romcache.sv
// Two-entry LRU read cache turning byte-wide CPU ROM reads into 32-bit SDRAM fetches.
// Hits answer combinationally; misses run a req/ack/dok handshake that is never aborted.
module jtdd_romcache
  import jtdd_romcache_pkg::*;
#(
  parameter int unsigned AW = 18
) (
  input logic             clk,
  input logic             rst,
  jtdd_romcache_if.slave  bus
);

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-3:0] addr_q, addr_d;
  logic          victim_q, victim_d;
  logic          lru_q, lru_d;
  logic          discard_q, discard_d;
  logic          fill;
  logic          hit0, hit1, hit_any;
  logic [7:0]    dout0, dout1;

  jtdd_romcache_way #(.AW(AW)) u_way0 (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .wr      (fill & ~victim_q),
    .wr_tag  (addr_q),
    .wr_data (bus.sdram_data),
    .cs      (bus.cpu_cs),
    .addr    (bus.cpu_addr),
    .hit     (hit0),
    .dout    (dout0)
  );

  jtdd_romcache_way #(.AW(AW)) u_way1 (
    .clk     (clk),
    .rst     (rst),
    .flush   (bus.flush),
    .wr      (fill & victim_q),
    .wr_tag  (addr_q),
    .wr_data (bus.sdram_data),
    .cs      (bus.cpu_cs),
    .addr    (bus.cpu_addr),
    .hit     (hit1),
    .dout    (dout1)
  );

  // Hits are masked while flushing so the CPU never sees a line being invalidated.
  assign hit_any = (hit0 | hit1) & ~bus.flush;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    victim_d  = victim_q;
    lru_d     = lru_q;
    discard_d = discard_q;
    fill      = 1'b0;

    // Victim becomes the way not just hit: hit on way 0 -> lru 1, on way 1 -> lru 0.
    if (hit_any) lru_d = hit0;
    if (bus.flush && state_q != StIdle) discard_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_cs && !(hit0 | hit1) && !bus.flush) begin
          state_d  = StReq;
          addr_d   = bus.cpu_addr[AW-1:2];
          victim_d = lru_q;
          req_d    = 1'b1;
        end
      end
      StReq: begin
        if (bus.sdram_ack) begin
          state_d = StWait;
          req_d   = 1'b0;
        end
      end
      StWait: begin
        if (bus.sdram_dok) begin
          state_d   = StIdle;
          discard_d = 1'b0;
          if (!discard_q && !bus.flush) begin
            fill  = 1'b1;
            lru_d = ~victim_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      victim_q  <= 1'b0;
      lru_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      victim_q  <= victim_d;
      lru_q     <= lru_d;
      discard_q <= discard_d;
    end
  end

  assign bus.sdram_req  = req_q;
  assign bus.sdram_addr = addr_q;
  assign bus.cpu_ok     = hit_any;
  assign bus.cpu_data   = !hit_any ? 8'hFF : (hit0 ? dout0 : dout1);

endmodule
